// File: rtl/conv_engine.sv
// ---------------------------------------------------------------------------
// conv_engine
//   Sequential unsigned linear convolution engine.
//   y[n] = sum_{k=kmin..kmax} x[k] * h[n-k],  n = 0 .. Nx+Nh-2
//   kmin = max(0, n-Nh+1), kmax = min(n, Nx-1)
//
//   Each output takes L+3 cycles (L = kmax-kmin+1):
//     SETUP (1) -> MAC (L) -> DRAIN (1) -> WRITE (1)
//
// Ports
//   clk           : clock, all logic on posedge
//   rst           : synchronous active-high reset
//   start_i       : one-cycle start request (ignored while busy_o)
//   size_x_i      : Nx, number of x samples (sampled on accepted start)
//   size_h_i      : Nh, number of h samples (sampled on accepted start)
//   mem_x_addr_o  : x memory read address
//   mem_x_data_i  : x read data, valid one cycle after the address
//   mem_h_addr_o  : h memory read address
//   mem_h_data_i  : h read data, valid one cycle after the address
//   mem_y_we_o    : y memory write enable (one pulse per output)
//   mem_y_addr_o  : y write address (n)
//   mem_y_data_o  : y write data (accumulator)
//   busy_o        : high in SETUP/MAC/DRAIN/WRITE
//   done_o        : sticky completion flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module conv_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] size_x_i,
    input  logic [ADDR_WIDTH-1:0] size_h_i,
    output logic [ADDR_WIDTH-1:0] mem_x_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_x_data_i,
    output logic [ADDR_WIDTH-1:0] mem_h_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_h_data_i,
    output logic                  mem_y_we_o,
    output logic [ADDR_WIDTH:0]   mem_y_addr_o,
    output logic [ACC_WIDTH-1:0]  mem_y_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int NW = ADDR_WIDTH + 1;
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] nx;
    logic [ADDR_WIDTH-1:0] nh;
    logic [NW-1:0]         n;
    logic [ADDR_WIDTH-1:0] k;
    logic [ADDR_WIDTH-1:0] kmax;
    logic [ACC_WIDTH-1:0]  acc;
    // Set for the cycle after a MAC cycle: the memory data on the inputs
    // belongs to the address issued in that MAC cycle and must be summed.
    logic                  pend;

    logic [NW-1:0]         nx_ext;
    logic [NW-1:0]         nh_ext;
    logic [NW-1:0]         last_n;
    logic [ADDR_WIDTH-1:0] kmin_c;
    logic [ADDR_WIDTH-1:0] kmax_c;
    logic [ADDR_WIDTH-1:0] k_nxt;
    logic [ADDR_WIDTH-1:0] h_nxt;
    logic [PW-1:0]         prod;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  acc_sum;

    always_comb begin
        nx_ext = {1'b0, nx};
        nh_ext = {1'b0, nh};
        last_n = NW'(nx_ext + nh_ext - NW'(2));

        if (n >= nh_ext)
            kmin_c = ADDR_WIDTH'(n - nh_ext + NW'(1));
        else
            kmin_c = '0;

        if (n < nx_ext)
            kmax_c = ADDR_WIDTH'(n);
        else
            kmax_c = nx - ADDR_WIDTH'(1);

        // Address pair for the next MAC cycle: first term from SETUP,
        // successive terms while stepping through MAC.
        if (state == SETUP)
            k_nxt = kmin_c;
        else
            k_nxt = k + ADDR_WIDTH'(1);
        h_nxt = ADDR_WIDTH'(n - {1'b0, k_nxt});

        prod     = PW'(mem_x_data_i) * PW'(mem_h_data_i);
        prod_ext = ACC_WIDTH'(prod);
        if (pend)
            acc_sum = acc + prod_ext;
        else
            acc_sum = acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            nx           <= '0;
            nh           <= '0;
            n            <= '0;
            k            <= '0;
            kmax         <= '0;
            acc          <= '0;
            pend         <= 1'b0;
            mem_x_addr_o <= '0;
            mem_h_addr_o <= '0;
            mem_y_we_o   <= 1'b0;
            mem_y_addr_o <= '0;
            mem_y_data_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            mem_y_we_o <= 1'b0;
            pend       <= (state == MAC);
            acc        <= acc_sum;

            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        nx <= size_x_i;
                        nh <= size_h_i;
                        n  <= '0;
                        if (size_x_i == '0 || size_h_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= SETUP;
                            busy_o <= 1'b1;
                            done_o <= 1'b0;
                        end
                    end
                end

                SETUP: begin
                    acc          <= '0;
                    k            <= k_nxt;
                    kmax         <= kmax_c;
                    mem_x_addr_o <= k_nxt;
                    mem_h_addr_o <= h_nxt;
                    state        <= MAC;
                end

                MAC: begin
                    if (k == kmax) begin
                        state <= DRAIN;
                    end else begin
                        k            <= k_nxt;
                        mem_x_addr_o <= k_nxt;
                        mem_h_addr_o <= h_nxt;
                    end
                end

                DRAIN: begin
                    // acc_sum already includes the last product here.
                    mem_y_we_o   <= 1'b1;
                    mem_y_addr_o <= n;
                    mem_y_data_o <= acc_sum;
                    state        <= WRITE;
                end

                WRITE: begin
                    if (n == last_n) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        n     <= n + NW'(1);
                        state <= SETUP;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_engine.sv
module tb_conv_engine;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int CW = 2*DW + AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] size_x_i;
    logic [AW-1:0] size_h_i;
    logic [AW-1:0] mem_x_addr_o;
    logic [DW-1:0] mem_x_data_i;
    logic [AW-1:0] mem_h_addr_o;
    logic [DW-1:0] mem_h_data_i;
    logic          mem_y_we_o;
    logic [AW:0]   mem_y_addr_o;
    logic [CW-1:0] mem_y_data_o;
    logic          busy_o;
    logic          done_o;

    conv_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .size_x_i     (size_x_i),
        .size_h_i     (size_h_i),
        .mem_x_addr_o (mem_x_addr_o),
        .mem_x_data_i (mem_x_data_i),
        .mem_h_addr_o (mem_h_addr_o),
        .mem_h_data_i (mem_h_data_i),
        .mem_y_we_o   (mem_y_we_o),
        .mem_y_addr_o (mem_y_addr_o),
        .mem_y_data_o (mem_y_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Registered-read memories, one cycle latency.
    logic [DW-1:0] xmem [32];
    logic [DW-1:0] hmem [32];
    always @(posedge clk) begin
        mem_x_data_i <= xmem[mem_x_addr_o];
        mem_h_data_i <= hmem[mem_h_addr_o];
    end

    typedef struct packed {
        logic [AW:0]   a;
        logic [CW-1:0] d;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int wr_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected write per observed mem_y_we_o.
    always @(negedge clk) begin
        if (busy_o) busy_cnt++;
        if (mem_y_we_o) begin
            exp_t e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected none",
                         mem_y_addr_o, mem_y_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("y_addr", mem_y_addr_o, e.a);
                chk("y_data", mem_y_data_o, e.d);
            end
        end
    end

    task automatic push(input int a, input int d);
        exp_t e;
        e.a = (AW+1)'(a);
        e.d = CW'(d);
        exp_q.push_back(e);
    endtask

    task automatic start_run(input int nx, input int nh);
        @(posedge clk); #1;
        size_x_i = AW'(nx);
        size_h_i = AW'(nh);
        start_i  = 1'b1;
        busy_cnt = 0;
        wr_cnt   = 0;
        @(posedge clk); #1;
        start_i  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int c = 0;
        while (!(done_o && !busy_o) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (c >= maxc) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy %0d done %0d expected done within %0d cycles",
                     name, busy_o, done_o, maxc);
        end
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_xaddr"}, mem_x_addr_o, 0);
        chk({name, "_haddr"}, mem_h_addr_o, 0);
        chk({name, "_we"},    mem_y_we_o,   0);
        chk({name, "_yaddr"}, mem_y_addr_o, 0);
        chk({name, "_ydata"}, mem_y_data_o, 0);
        chk({name, "_busy"},  busy_o,       0);
        chk({name, "_done"},  done_o,       0);
    endtask

    task automatic load_3x2();
        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
        hmem[0] = 8'd1; hmem[1] = 8'd1;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; size_x_i = '0; size_h_i = '0;
        for (int i = 0; i < 32; i++) begin xmem[i] = '0; hmem[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;

        // 1x1: single product
        xmem[0] = 8'd3; hmem[0] = 8'd4;
        push(0, 12);
        start_run(1, 1);
        wait_done("t1", 100);
        chk("t1_busy_cycles", busy_cnt, 4);
        chk("t1_writes", wr_cnt, 1);
        chk("t1_done", done_o, 1);

        // 3x2
        load_3x2();
        push(0, 1); push(1, 3); push(2, 5); push(3, 3);
        start_run(3, 2);
        wait_done("t2", 200);
        chk("t2_busy_cycles", busy_cnt, 18);
        chk("t2_writes", wr_cnt, 4);
        chk("t2_done", done_o, 1);

        // 4x3 with distinct values
        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3; xmem[3] = 8'd4;
        hmem[0] = 8'd5; hmem[1] = 8'd6; hmem[2] = 8'd7;
        push(0, 5); push(1, 16); push(2, 34); push(3, 52); push(4, 45); push(5, 28);
        start_run(4, 3);
        wait_done("t3", 300);
        chk("t3_busy_cycles", busy_cnt, 30);
        chk("t3_writes", wr_cnt, 6);

        // Nh > Nx
        xmem[0] = 8'd2; xmem[1] = 8'd3;
        hmem[0] = 8'd1; hmem[1] = 8'd2; hmem[2] = 8'd3;
        push(0, 2); push(1, 7); push(2, 12); push(3, 9);
        start_run(2, 3);
        wait_done("t4", 200);
        chk("t4_writes", wr_cnt, 4);

        // Maximum size, all 0xFF: y[n] = L(n) * 65025
        for (int i = 0; i < 32; i++) begin xmem[i] = 8'hFF; hmem[i] = 8'hFF; end
        for (int nn = 0; nn <= 60; nn++) begin
            int lo, hi;
            lo = (nn > 30) ? nn - 30 : 0;
            hi = (nn < 30) ? nn : 30;
            if (nn == 30) push(30, 2015775);
            else          push(nn, (hi - lo + 1) * 65025);
        end
        start_run(31, 31);
        wait_done("t5", 3000);
        chk("t5_writes", wr_cnt, 61);
        chk("t5_busy_cycles", busy_cnt, 1144);

        // Start pulsed mid-run with other sizes is ignored
        load_3x2();
        push(0, 1); push(1, 3); push(2, 5); push(3, 3);
        start_run(3, 2);
        repeat (5) @(posedge clk);
        #1;
        size_x_i = 5'd5; size_h_i = 5'd5; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done("t6", 200);
        chk("t6_writes", wr_cnt, 4);
        chk("t6_busy_cycles", busy_cnt, 18);

        // Reset during MAC of the second output
        load_3x2();
        push(0, 1);
        start_run(3, 2);
        begin
            int c = 0;
            while (!mem_y_we_o && c < 50) begin @(negedge clk); c++; end
            chk("t7_first_write_seen", mem_y_we_o, 1);
        end
        @(posedge clk);          // WRITE -> SETUP
        @(posedge clk); #1;      // SETUP -> MAC (n=1)
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero_outputs("t7_after_rst");
        @(negedge clk);
        chk("t7_no_we", mem_y_we_o, 0);
        rst = 1'b0;
        chk("t7_queue_empty", exp_q.size(), 0);
        push(0, 1); push(1, 3); push(2, 5); push(3, 3);
        start_run(3, 2);
        wait_done("t7b", 200);
        chk("t7b_writes", wr_cnt, 4);

        // Zero-size start after a reset: straight to DONE, no writes
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("t8_done_before", done_o, 0);
        start_run(0, 5);
        chk("t8_done", done_o, 1);
        repeat (4) @(negedge clk);
        chk("t8_busy_cycles", busy_cnt, 0);
        chk("t8_writes", wr_cnt, 0);
        chk("t8_done_sticky", done_o, 1);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the x and h samples.
REQ-002 Parameter ADDR_WIDTH, default 5: address width of the x and h memories; the y address is ADDR_WIDTH+1 bits.
REQ-003 Parameter ACC_WIDTH, default 2*DATA_WIDTH+ADDR_WIDTH: accumulator and y data width.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start_i  input  1  one-cycle start request.
REQ-007 size_x_i  input  ADDR_WIDTH  number of x samples, Nx.
REQ-008 size_h_i  input  ADDR_WIDTH  number of h samples, Nh.
REQ-009 mem_x_addr_o  output  ADDR_WIDTH  x memory read address.
REQ-010 mem_x_data_i  input  DATA_WIDTH  x read data, registered, valid 1 cycle after the address.
REQ-011 mem_h_addr_o  output  ADDR_WIDTH  h memory read address.
REQ-012 mem_h_data_i  input  DATA_WIDTH  h read data, registered, 1-cycle latency.
REQ-013 mem_y_we_o  output  1  y memory write enable.
REQ-014 mem_y_addr_o  output  ADDR_WIDTH+1  y write address.
REQ-015 mem_y_data_o  output  ACC_WIDTH  y write data.
REQ-016 busy_o  output  1  high while an operation is in progress.
REQ-017 done_o  output  1  sticky completion flag.

Function
REQ-018 The block SHALL compute the unsigned linear convolution y[n]=sum x[k]*h[n-k] for n=0..Nx+Nh-2, over k=kmin..kmax, where kmin=max(0,n-Nh+1) and kmax=min(n,Nx-1).
REQ-019 The FSM states SHALL be IDLE, SETUP, MAC, DRAIN, WRITE and DONE.
REQ-020 From IDLE or DONE, start_i=1 SHALL latch Nx and Nh, set n=0, clear done_o, and go to SETUP; if Nx=0 or Nh=0 it SHALL instead go directly to DONE with no writes.
REQ-021 SETUP (1 cycle) SHALL clear the accumulator, set k=kmin, and go to MAC.
REQ-022 MAC SHALL drive mem_x_addr_o=k and mem_h_addr_o=n-k for one k per cycle, accumulating the product of the data returned for the previous cycle's address.
REQ-023 After issuing kmax, MAC SHALL go to DRAIN (1 cycle), which accumulates the last product and then goes to WRITE.
REQ-024 WRITE (1 cycle) SHALL assert mem_y_we_o=1 with mem_y_addr_o=n and mem_y_data_o=accumulator, then go to SETUP with n+1, or to DONE if n=Nx+Nh-2.
REQ-025 Cycles per output SHALL be L+3, where L=kmax-kmin+1; no other cycles SHALL be inserted.
REQ-026 Products SHALL be 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH; the accumulator SHALL never overflow for legal sizes.
REQ-027 mem_y_we_o SHALL be 1 only in WRITE, exactly one cycle per output, with addresses strictly ascending from 0.
REQ-028 busy_o SHALL be 1 in SETUP, MAC, DRAIN and WRITE, and 0 in IDLE and DONE.
REQ-029 done_o SHALL be 1 in DONE and remain 1 until the next accepted start_i.
REQ-030 start_i SHALL be ignored while busy_o=1; input sizes SHALL be sampled only when start is accepted.
REQ-031 DONE SHALL behave as IDLE for start acceptance.

Reset
REQ-032 When rst=1 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (addresses, we, data, busy_o, done_o), with the accumulator and counters cleared.
REQ-033 rst SHALL take priority over start_i and abort any operation immediately; no mem_y_we_o pulse SHALL occur in the cycle after reset is applied.
REQ-034 Memory contents SHALL NOT be affected by reset.

Verification
REQ-035 Nx=1, Nh=1, x={3}, h={4} -> one write, y[0]=12 at addr 0; busy_o high for 4 cycles; done_o=1 afterwards.
REQ-036 Nx=3, Nh=2, x={1,2,3}, h={1,1} -> y={1,3,5,3} at addresses 0..3; busy_o high for 18 cycles.
REQ-037 Nx=Nh=31, all samples 0xFF -> y[30]=31*65025=2015775 with no overflow; 61 writes total.
REQ-038 start_i pulsed mid-run with different sizes -> ignored; results match the first sizes.
REQ-039 rst asserted during MAC of the second output -> next cycle all outputs are 0 and the FSM is in IDLE; a subsequent start then produces a correct full result.
REQ-040 start_i with Nx=0, Nh=5 -> no mem_y_we_o pulse; done_o=1 one cycle later; busy_o stays 0.
